dsp_unpack4_cin: RTL and testbench

DSP_UNPACK4_CIN -- requirements
Module: dsp_unpack4_cin

---
 rtl/dsp_unpack4_cin_pkg.sv | 18 +
 rtl/dsp_unpack_lane.sv | 12 +
 rtl/dsp_unpack4_cin.sv | 95 +++++++++
 tb/tb_dsp_unpack4_cin.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dsp_unpack4_cin_pkg.sv
// dsp_unpack4_cin_pkg: shared widths and lane/beat types for the 4-word DSP unpacker
package dsp_unpack4_cin_pkg;
    localparam int PACK_W    = 48;
    localparam int FIELD_W   = 18;
    localparam int GUARD_LSB = 35;
    localparam int LANES     = 4;

    typedef struct packed {
        logic [FIELD_W-1:0] low;
        logic [FIELD_W-1:0] high;
        logic               cin;
    } lane_t;

    typedef struct packed {
        lane_t [LANES-1:0] lane;
        logic              dsp_reset;
    } beat_t;
endpackage

// File: rtl/dsp_unpack_lane.sv
// dsp_unpack_lane: splits one packed 48-bit word into low/high/cin and flags guard-bit overflow
module dsp_unpack_lane
    import dsp_unpack4_cin_pkg::*;
(
    input  logic [PACK_W-1:0] word,
    output lane_t             lane,
    output logic              ovf
);
    // high + cin recovers H because the signed low field borrowed one from it when negative
    assign lane = '{low: word[FIELD_W-1:0], high: word[2*FIELD_W-1:FIELD_W], cin: word[FIELD_W-1]};
    assign ovf  = !((&word[PACK_W-1:GUARD_LSB]) || !(|word[PACK_W-1:GUARD_LSB]));
endmodule

// File: rtl/dsp_unpack4_cin.sv
// dsp_unpack4_cin: unpacks four packed DSP words into signed fields plus carries,
// through a LATENCY-deep stallable pipeline with sticky overflow flag and beat counter
module dsp_unpack4_cin
    import dsp_unpack4_cin_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int FIELD_W = 18
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PACK_W-1:0]         in_word [0:3],
    input  logic                      in_dsp_reset,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [FIELD_W-1:0] op0_l,
    output logic signed [FIELD_W-1:0] op1_l,
    output logic signed [FIELD_W-1:0] op4_l,
    output logic signed [FIELD_W-1:0] op5_l,
    output logic signed [FIELD_W-1:0] op2_h,
    output logic signed [FIELD_W-1:0] op3_h,
    output logic signed [FIELD_W-1:0] op6_h,
    output logic signed [FIELD_W-1:0] op7_h,
    output logic                      op2_cin,
    output logic                      op3_cin,
    output logic                      op6_cin,
    output logic                      op7_cin,
    output logic                      dsp_reset,
    output logic                      err,
    input  logic                      err_clr,
    output logic [15:0]               beat_cnt
);
    lane_t            lanes [LANES];
    logic [LANES-1:0] ovf;
    beat_t            in_beat;
    beat_t            stg [LATENCY];
    beat_t            last;
    logic [LATENCY-1:0] vld;
    logic             adv;
    logic             accept;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            dsp_unpack_lane u_lane (.word(in_word[g]), .lane(lanes[g]), .ovf(ovf[g]));
        end
    endgenerate

    assign in_beat   = {lanes[3], lanes[2], lanes[1], lanes[0], in_dsp_reset};
    assign out_valid = vld[LATENCY-1];
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv && !areset;
    assign accept    = in_valid && in_ready;

    // data registers only load on valid beats so bubbles keep the last value
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
        end else if (adv) begin
            vld[0] <= in_valid;
            if (in_valid) stg[0] <= in_beat;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) stg[i] <= stg[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            err      <= 1'b0;
            beat_cnt <= '0;
        end else begin
            err <= (accept && |ovf) || (err && !err_clr);
            if (accept && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
        end
    end

    assign last      = stg[LATENCY-1];
    assign op0_l     = last.lane[0].low;
    assign op1_l     = last.lane[1].low;
    assign op4_l     = last.lane[2].low;
    assign op5_l     = last.lane[3].low;
    assign op2_h     = last.lane[0].high;
    assign op3_h     = last.lane[1].high;
    assign op6_h     = last.lane[2].high;
    assign op7_h     = last.lane[3].high;
    assign op2_cin   = last.lane[0].cin;
    assign op3_cin   = last.lane[1].cin;
    assign op6_cin   = last.lane[2].cin;
    assign op7_cin   = last.lane[3].cin;
    assign dsp_reset = out_valid && last.dsp_reset;
endmodule

// File: tb/tb_dsp_unpack4_cin.sv
// tb_dsp_unpack4_cin: directed self-checking bench for dsp_unpack4_cin (LATENCY=2)
module tb_dsp_unpack4_cin;
    logic        clk = 0, areset = 1, in_valid = 0, out_ready = 1, in_dsp_reset = 0, err_clr = 0;
    logic [47:0] in_word [0:3];
    logic        in_ready, out_valid, dsp_reset, err;
    logic        op2_cin, op3_cin, op6_cin, op7_cin;
    logic [17:0] op0_l, op1_l, op4_l, op5_l, op2_h, op3_h, op6_h, op7_h;
    logic [15:0] beat_cnt;
    int          n_cmp = 0, n_bad = 0;
    int          got_id[$];
    logic        got_dr[$];

    dsp_unpack4_cin #(.LATENCY(2), .FIELD_W(18)) dut (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_dsp_reset(in_dsp_reset), .out_valid(out_valid),
        .out_ready(out_ready), .op0_l(op0_l), .op1_l(op1_l), .op4_l(op4_l), .op5_l(op5_l),
        .op2_h(op2_h), .op3_h(op3_h), .op6_h(op6_h), .op7_h(op7_h),
        .op2_cin(op2_cin), .op3_cin(op3_cin), .op6_cin(op6_cin), .op7_cin(op7_cin),
        .dsp_reset(dsp_reset), .err(err), .err_clr(err_clr), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // word0 carries the beat id in its low field; beat 1 sits at the output during the stall window
    task automatic stream(input int n, input int s_lo, input int s_hi, input int dr);
        int nb = 1;
        got_id.delete();
        got_dr.delete();
        for (int c = 0; c < n + s_hi + 6; c++) begin
            @(negedge clk);
            out_ready    = !(c >= s_lo && c < s_hi);
            in_valid     = nb <= n;
            in_word[0]   = 48'(nb);
            in_dsp_reset = nb == dr;
            #1;
            if (out_valid && !out_ready) begin
                check("stall_ready", 64'(in_ready), 64'(0));
                check("stall_hold", 64'(op0_l), 64'(1));
            end
            if (out_valid && out_ready) begin
                got_id.push_back(int'(op0_l));
                got_dr.push_back(dsp_reset);
            end
            if (in_valid && in_ready) nb++;
        end
        in_valid     = 0;
        in_dsp_reset = 0;
    endtask

    initial begin
        int stale = 0;
        foreach (in_word[k]) in_word[k] = '0;
        #1;
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_cnt", 64'(beat_cnt), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        @(negedge clk);
        @(negedge clk);
        areset = 0;
        #1;
        check("ready_after_rst", 64'(in_ready), 64'(1));
        // H=5,L=-3 / H=-2,L=100 / zero / H=-1,L=-1
        in_word[0] = 48'h00000013FFFD;
        in_word[1] = 48'hFFFFFFF80064;
        in_word[3] = 48'hFFFFFFFBFFFF;
        in_valid   = 1;
        @(negedge clk);
        in_valid = 0;
        #1;
        check("lat_c1_valid", 64'(out_valid), 64'(0));
        check("cnt_1", 64'(beat_cnt), 64'(1));
        @(negedge clk);
        #1;
        check("lat_c2_valid", 64'(out_valid), 64'(1));
        check("op0_l", 64'(op0_l), 64'(18'h3FFFD));
        check("op2_h", 64'(op2_h), 64'(4));
        check("op2_cin", 64'(op2_cin), 64'(1));
        check("sum0", 64'(18'(op2_h + 18'(op2_cin))), 64'(5));
        check("op1_l", 64'(op1_l), 64'(100));
        check("op3_h", 64'(op3_h), 64'(18'h3FFFE));
        check("op3_cin", 64'(op3_cin), 64'(0));
        check("op5_l", 64'(op5_l), 64'(18'h3FFFF));
        check("op7_h", 64'(op7_h), 64'(18'h3FFFE));
        check("op7_cin", 64'(op7_cin), 64'(1));
        check("no_err", 64'(err), 64'(0));
        @(negedge clk);
        #1;
        check("lat_c3_valid", 64'(out_valid), 64'(0));
        check("bubble_hold", 64'(op0_l), 64'(18'h3FFFD));
        foreach (in_word[k]) in_word[k] = '0;

        stream(4, 2, 5, 0);
        check("stall_count", 64'(got_id.size()), 64'(4));
        for (int i = 0; i < 4; i++) check($sformatf("order%0d", i), 64'(got_id[i]), 64'(i + 1));
        check("cnt_5", 64'(beat_cnt), 64'(5));

        @(negedge clk);
        out_ready  = 1;
        in_word[2] = 48'h000800000000;
        in_valid   = 1;
        @(negedge clk);
        in_valid   = 0;
        in_word[2] = '0;
        #1;
        check("ovf_err", 64'(err), 64'(1));
        @(negedge clk);
        #1;
        check("ovf_valid", 64'(out_valid), 64'(1));
        check("ovf_op4_l", 64'(op4_l), 64'(0));
        // bit 35 lands in the top bit of the raw high field
        check("ovf_op6_h", 64'(op6_h), 64'(18'h20000));
        check("ovf_op6_cin", 64'(op6_cin), 64'(0));
        err_clr    = 1;
        in_word[2] = 48'h000800000000;
        in_valid   = 1;
        @(negedge clk);
        in_valid   = 0;
        in_word[2] = '0;
        #1;
        check("clr_vs_ovf", 64'(err), 64'(1));
        @(negedge clk);
        err_clr = 0;
        #1;
        check("clr", 64'(err), 64'(0));
        check("cnt_7", 64'(beat_cnt), 64'(7));

        stream(5, 0, 0, 3);
        check("dr_count", 64'(got_id.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("dr_id%0d", i), 64'(got_id[i]), 64'(i + 1));
            check($sformatf("dr_flag%0d", i), 64'(got_dr[i]), 64'(i == 2));
        end
        check("dr_idle", 64'(dsp_reset), 64'(0));
        check("cnt_12", 64'(beat_cnt), 64'(12));

        @(negedge clk);
        out_ready  = 0;
        in_valid   = 1;
        in_word[0] = 48'h2A;
        @(negedge clk);
        in_word[0] = 48'h2B;
        @(negedge clk);
        in_valid = 0;
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        check("pre_rst_op0", 64'(op0_l), 64'(18'h2A));
        #1 areset = 1;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_op0", 64'(op0_l), 64'(0));
        check("arst_cnt", 64'(beat_cnt), 64'(0));
        check("arst_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        areset    = 0;
        out_ready = 1;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'(1));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("no_stale", 64'(stale), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
